// File: rtl/line_refill_master.sv
// line_refill_master: AHB-Lite read master that refills one I-cache line.
// On a miss it issues an aligned INCR4 word burst, packs the four returned
// words into a line (word k at bits [32k+31:32k]) and presents the line to
// the cache array for one cycle. An ERROR response aborts the refill.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   miss_req, miss_addr    refill request and any byte address in the line
//   busy                   refill in progress
//   refill_valid           one-cycle pulse, refill_line/refill_addr valid
//   refill_line            assembled line
//   refill_addr            line-aligned address of refill_line
//   refill_err             one-cycle pulse, burst aborted by ERROR
//   HADDR..HWRITE          AHB-Lite master address/control
//   HREADY, HRESP, HRDATA  AHB-Lite slave response
module line_refill_master #(
  parameter int unsigned CACHE_LINE = 128
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  miss_req,
  input  logic [31:0]           miss_addr,
  output logic                  busy,
  output logic                  refill_valid,
  output logic [CACHE_LINE-1:0] refill_line,
  output logic [31:0]           refill_addr,
  output logic                  refill_err,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [31:0]           HRDATA
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = CACHE_LINE / WORD_W;
  localparam int unsigned CNT_W   = 3;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_WORDS - 1);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_BURST, S_DRAIN, S_DONE, S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [CNT_W-1:0]        a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]        d_cnt_q, d_cnt_d;
  logic [CACHE_LINE-1:0]   line_buf_q, line_buf_d;
  logic [CACHE_LINE-1:0]   refill_line_q, refill_line_d;
  logic [ADDR_W-1:0]       refill_addr_q, refill_addr_d;
  logic                    refill_valid_q, refill_valid_d;
  logic                    refill_err_q, refill_err_d;
  logic                    busy_q, busy_d;
  logic [ADDR_W-1:0]       haddr_q, haddr_d;
  logic [1:0]              htrans_q, htrans_d;

  logic accept, data_pend, err_first, err_last, beat_ok;

  // A data phase is outstanding whenever more address beats completed than data beats.
  always_comb begin
    accept    = (state_q == S_IDLE) && miss_req && !busy_q;
    data_pend = ((state_q == S_BURST) || (state_q == S_DRAIN)) && (d_cnt_q < a_cnt_q);
    err_first = data_pend && HRESP && !HREADY;
    // ERROR without the preceding wait cycle is treated as an immediate abort.
    err_last  = data_pend && HRESP && HREADY;
    beat_ok   = data_pend && HREADY && !HRESP;
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_BURST;
      S_BURST: begin
        if (err_first)                           state_d = S_ERR;
        else if (err_last)                       state_d = S_IDLE;
        else if (HREADY && a_cnt_q == LAST_BEAT) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (err_first)    state_d = S_ERR;
        else if (err_last) state_d = S_IDLE;
        else if (beat_ok)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   if (HREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    base_d         = base_q;
    a_cnt_d        = a_cnt_q;
    d_cnt_d        = d_cnt_q;
    line_buf_d     = line_buf_q;
    refill_line_d  = refill_line_q;
    refill_addr_d  = refill_addr_q;
    haddr_d        = haddr_q;
    htrans_d       = TR_IDLE;
    refill_valid_d = 1'b0;
    refill_err_d   = ((state_q == S_ERR) && HREADY) || err_last;

    if (accept) begin
      base_d  = miss_addr & ~ADDR_W'(32'hF);
      a_cnt_d = '0;
      d_cnt_d = '0;
    end

    if ((state_q == S_BURST) && HREADY) a_cnt_d = a_cnt_q + CNT_W'(1);

    if (beat_ok) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (d_cnt_q == CNT_W'(k)) line_buf_d[k*WORD_W +: WORD_W] = HRDATA;
      end
      d_cnt_d = d_cnt_q + CNT_W'(1);
    end

    // Published line only changes on a successful refill; partial lines are dropped.
    if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
      refill_line_d  = line_buf_d;
      refill_addr_d  = base_q;
      refill_valid_d = 1'b1;
    end

    // busy stays up through the refill_err cycle so that cycle cannot accept.
    busy_d = (state_d != S_IDLE) || refill_err_d;

    // Address/control derive from next-cycle counters, so they hold while HREADY=0.
    if (state_d == S_BURST) begin
      htrans_d = (a_cnt_d == '0) ? TR_NONSEQ : TR_SEQ;
      haddr_d  = base_d + ADDR_W'({a_cnt_d[1:0], 2'b00});
    end
  end

  // Datapath and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      base_q         <= '0;
      a_cnt_q        <= '0;
      d_cnt_q        <= '0;
      line_buf_q     <= '0;
      refill_line_q  <= '0;
      refill_addr_q  <= '0;
      refill_valid_q <= 1'b0;
      refill_err_q   <= 1'b0;
      busy_q         <= 1'b0;
      haddr_q        <= '0;
      htrans_q       <= TR_IDLE;
    end else begin
      base_q         <= base_d;
      a_cnt_q        <= a_cnt_d;
      d_cnt_q        <= d_cnt_d;
      line_buf_q     <= line_buf_d;
      refill_line_q  <= refill_line_d;
      refill_addr_q  <= refill_addr_d;
      refill_valid_q <= refill_valid_d;
      refill_err_q   <= refill_err_d;
      busy_q         <= busy_d;
      haddr_q        <= haddr_d;
      htrans_q       <= htrans_d;
    end
  end

  assign busy         = busy_q;
  assign refill_valid = refill_valid_q;
  assign refill_line  = refill_line_q;
  assign refill_addr  = refill_addr_q;
  assign refill_err   = refill_err_q;
  assign HADDR        = haddr_q;
  assign HTRANS       = htrans_q;
  assign HBURST       = 3'b011;
  assign HSIZE        = 3'b010;
  assign HWRITE       = 1'b0;

endmodule

// File: tb/tb_line_refill_master.sv
// Testbench for line_refill_master: AHB slave model with random wait states
// and error injection, checked against line/latency expectations derived
// from the burst rules (5 cycles + one per wait state, words from memory).
module tb_line_refill_master;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         busy;
  logic         refill_valid;
  logic [127:0] refill_line;
  logic [31:0]  refill_addr;
  logic         refill_err;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic [2:0]   HSIZE;
  logic         HWRITE;
  logic         HREADY;
  logic         HRESP;
  logic [31:0]  HRDATA;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] model_line;
  logic [31:0]  model_addr;
  logic [31:0]  mem_seed;

  line_refill_master #(.CACHE_LINE(128)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .refill_valid(refill_valid), .refill_line(refill_line),
    .refill_addr(refill_addr), .refill_err(refill_err), .HADDR(HADDR),
    .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the slave model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_seed == 32'h0) return a - 32'hA00;
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // Called at #1 after an edge with busy=0; request is sampled at the next edge.
  task automatic request(input logic [31:0] a);
    miss_addr = a;
    miss_req  = 1'b1;
    @(posedge HCLK); #1;
    miss_req  = 1'b0;
    miss_addr = $urandom;
  endtask

  // Acts as the AHB slave from the cycle after acceptance until completion.
  task automatic serve(input logic [31:0] maddr, input int st0, input int st1,
                       input int st2, input int st3, input int err_beat,
                       input int raise_at, input logic [31:0] raise_addr, input bit tail);
    int stalls [4];
    logic [31:0]  base, pend_addr, cur_haddr, prev_haddr, hrdata_v;
    logic [1:0]   cur_htrans, prev_htrans;
    logic [127:0] exp_line;
    int           exp_cyc, stall_tot, cyc, beat_a, beat_d, stall_left;
    bit           pend, prev_hready, prev_resp, err_phase, done_ok, done_err, hready_v, hresp_v;
    stalls    = '{st0, st1, st2, st3};
    base      = {maddr[31:4], 4'h0};
    stall_tot = 0;
    for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = mem_word(base + 32'(4*k));
    if (err_beat < 0) begin
      for (int k = 0; k < 4; k++) stall_tot += stalls[k];
      exp_cyc = 5 + stall_tot;
    end else begin
      for (int k = 0; k < err_beat; k++) stall_tot += stalls[k];
      exp_cyc = err_beat + 3 + stall_tot;
    end
    cyc = 0; beat_a = 0; beat_d = 0; pend = 0; pend_addr = '0;
    prev_hready = 1; prev_resp = 0; err_phase = 0; done_ok = 0; done_err = 0;
    prev_haddr = '0; prev_htrans = '0; stall_left = stalls[0];
    while (cyc < 100 && !done_ok && !done_err) begin
      if (refill_valid) done_ok = 1;
      else if (refill_err) done_err = 1;
      else begin
        if (cyc == raise_at) begin miss_req = 1'b1; miss_addr = raise_addr; end
        cur_haddr  = HADDR;
        cur_htrans = HTRANS;
        check_eq("busy_mid", busy, 1'b1);
        if (cur_htrans[1] && prev_hready) begin
          check_eq("addr_beat", cur_haddr, base + 32'(4*beat_a));
          check_eq("trans_beat", cur_htrans, (beat_a == 0) ? 2'b10 : 2'b11);
        end
        if (!prev_hready && !prev_resp) begin
          check_eq("stall_haddr", cur_haddr, prev_haddr);
          check_eq("stall_htrans", cur_htrans, prev_htrans);
        end
        if (err_phase) check_eq("err_htrans_idle", cur_htrans, 2'b00);
        hready_v = 1; hresp_v = 0; hrdata_v = $urandom;
        if (pend) begin
          if (beat_d == err_beat) begin
            hresp_v = 1; hready_v = err_phase; err_phase = 1;
          end else if (stall_left > 0) begin
            hready_v = 0; stall_left--;
          end else hrdata_v = mem_word(pend_addr);
        end
        HREADY = hready_v; HRESP = hresp_v; HRDATA = hrdata_v;
        @(posedge HCLK); #1;
        cyc++;
        if (hready_v) begin
          if (pend) begin
            beat_d++;
            stall_left = (beat_d < 4) ? stalls[beat_d] : 0;
          end
          pend      = cur_htrans[1];
          pend_addr = cur_haddr;
          if (cur_htrans[1]) beat_a++;
        end
        prev_hready = hready_v; prev_resp = hresp_v;
        prev_haddr  = cur_haddr; prev_htrans = cur_htrans;
      end
    end
    HREADY = 1'b1; HRESP = 1'b0;
    check_eq("completed", done_ok || done_err, 1'b1);
    check_eq("latency", cyc, exp_cyc);
    check_eq("busy_last", busy, 1'b1);
    if (err_beat < 0) begin
      check_eq("valid_not_err", done_ok, 1'b1);
      check_eq("refill_line", refill_line, exp_line);
      check_eq("refill_addr", refill_addr, base);
      model_line = exp_line;
      model_addr = base;
    end else begin
      check_eq("err_not_valid", done_err, 1'b1);
      check_eq("line_kept", refill_line, model_line);
      check_eq("addr_kept", refill_addr, model_addr);
    end
    if (tail) begin
      @(posedge HCLK); #1;
      check_eq("pulse_end", {refill_valid, refill_err}, 2'b00);
      check_eq("busy_low", busy, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_pulses"}, {refill_valid, refill_err}, 2'b00);
    check_eq({tag, "_htrans"}, HTRANS, 2'b00);
    check_eq({tag, "_haddr"}, HADDR, 32'h0);
    check_eq({tag, "_line"}, refill_line, 128'h0);
    check_eq({tag, "_raddr"}, refill_addr, 32'h0);
    check_eq({tag, "_const"}, {HBURST, HSIZE, HWRITE}, 7'b011_010_0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int e;
    HRESETn = 1'b0; miss_req = 1'b0; miss_addr = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    mem_seed = '0; model_line = '0; model_addr = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Zero-wait refill, wait states, then error on data beat 2.
    request(32'h0000_0A18);
    serve(32'h0000_0A18, 0, 0, 0, 0, -1, -1, '0, 1);
    request(32'h0000_0A18);
    serve(32'h0000_0A18, 0, 2, 0, 0, -1, -1, '0, 1);
    request(32'h0000_0A18);
    serve(32'h0000_0A18, 0, 0, 0, 0, 2, -1, '0, 1);

    // Request held while busy: accepted only after busy drops.
    mem_seed = 32'h1234_5677;
    request(32'h0000_0B44);
    serve(32'h0000_0B44, 0, 1, 0, 0, -1, 2, 32'h0000_2000, 0);
    @(posedge HCLK); #1;
    check_eq("b2b_busy_gap", busy, 1'b0);
    check_eq("b2b_idle_gap", HTRANS, 2'b00);
    @(posedge HCLK); #1;
    check_eq("b2b_nonseq", HTRANS, 2'b10);
    check_eq("b2b_haddr", HADDR, 32'h0000_2000);
    miss_req = 1'b0;
    serve(32'h0000_2000, 0, 0, 0, 0, -1, -1, '0, 1);

    // Reset while address beat 2 is on the bus.
    request(32'h0000_3454);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    check_eq("rst_pre_haddr", HADDR, 32'h0000_3458);
    #2 HRESETn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge HCLK); #1;
    check_reset_outputs("midrst_hold");
    HRESETn = 1'b1;
    model_line = '0; model_addr = '0;
    @(posedge HCLK); #1;
    request(32'h0000_5A5C);
    serve(32'h0000_5A5C, 1, 0, 0, 1, -1, -1, '0, 1);

    // Random refills with random wait states and occasional ERROR.
    repeat (16) begin
      a        = $urandom;
      mem_seed = $urandom | 32'h1;
      e        = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      request(a);
      serve(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), e, -1, '0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
